// File: rtl/reg_write_arbiter_if.sv
// Write-request and register-bank signals between requesters and reg_write_arbiter.
// master = requester side, slave = arbiter side.
interface reg_write_arbiter_if #(
    parameter int NUM_REQ  = 2,
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 2
);
    logic                      en;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REGS-1:0]       reg_we;
    logic [DATA_W-1:0]         reg_d;
    logic                      busy;

    modport master (
        output en, req_valid, req_addr, req_data,
        input  req_ready, reg_we, reg_d, busy
    );

    modport slave (
        input  en, req_valid, req_addr, req_data,
        output req_ready, reg_we, reg_d, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter feeding a one-hot-enabled register bank through one commit stage.
// Optional saturating write counter on port wr_count when REG_ARB_WRCOUNT_EN is defined.
module reg_write_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    reg_write_arbiter_if.slave bus
`ifdef REG_ARB_WRCOUNT_EN
    ,
    output logic [7:0]         wr_count
`endif
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    rr_ptr_d;
    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                accept;
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [NUM_REGS-1:0] we_d;
    logic [NUM_REGS-1:0] we_q;
    logic [DATA_W-1:0]   d_d;
    logic [DATA_W-1:0]   d_q;
    logic [NUM_REGS-1:0] we_out;
    logic                busy_out;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && bus.req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                found      = 1'b1;
            end
        end
        if (!bus.en || rst) begin
            grant = '0;
        end
    end

    assign accept = |grant;

    always_comb begin
        we_d                      = '0;
        we_d[addr_arr[grant_idx]] = 1'b1;
        d_d                       = data_arr[grant_idx];
        if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = grant_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= '0;
            d_q      <= '0;
            rr_ptr_q <= '0;
        end else if (accept) begin
            we_q     <= we_d;
            d_q      <= d_d;
            rr_ptr_q <= rr_ptr_d;
        end else begin
            we_q     <= '0;
        end
    end

    // A commit still in the stage while rst is high is dropped rather than pulsed to the bank.
    assign we_out        = rst ? '0 : we_q;
    assign busy_out      = |we_out;
    assign bus.req_ready = grant;
    assign bus.reg_we    = we_out;
    assign bus.reg_d     = d_q;
    assign bus.busy      = busy_out;

`ifdef REG_ARB_WRCOUNT_EN
    logic [7:0] wr_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= '0;
        end else if (busy_out && (wr_count_q != 8'hFF)) begin
            wr_count_q <= wr_count_q + 8'd1;
        end
    end

    assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; inputs change on the falling edge and are checked 1ns later.
module tb_reg_write_arbiter;
    localparam int NUM_REQ  = 2;
    localparam int NUM_REGS = 4;
    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 2;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(
        .NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) bus ();

`ifdef REG_ARB_WRCOUNT_EN
    logic [7:0] wr_count;
`endif

    reg_write_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef REG_ARB_WRCOUNT_EN
        ,
        .wr_count(wr_count)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] v,
                         input logic [1:0] a0, input logic [3:0] d0,
                         input logic [1:0] a1, input logic [3:0] d1);
        rst           = r;
        bus.en        = e;
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
    endtask

    task automatic check_out(input string tag, input logic [1:0] rdy,
                             input logic [3:0] we, input logic [3:0] d);
        check_val({tag, "_ready"}, 32'(bus.req_ready), 32'(rdy));
        check_val({tag, "_we"},    32'(bus.reg_we),    32'(we));
        check_val({tag, "_d"},     32'(bus.reg_d),     32'(d));
        check_val({tag, "_busy"},  32'(bus.busy),      32'(we != 4'b0000));
    endtask

    logic [3:0] d0_tab [3] = '{4'h1, 4'h2, 4'h3};
    logic [3:0] d1_tab [3] = '{4'h8, 4'h9, 4'hA};
    logic [3:0] exp_we [6] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
    logic [3:0] exp_d  [6] = '{4'h1, 4'h8, 4'h2, 4'h9, 4'h3, 4'hA};

    initial begin
        drive(1'b1, 1'b1, 2'b11, 2'd0, 4'h0, 2'd0, 4'h0);
        @(posedge clk);

        // Reset holds everything quiet even with both requesters valid
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check_out($sformatf("rst%0d", i), 2'b00, 4'b0000, 4'h0);
        end

        // Single write: ready same cycle, commit next cycle, then idle
        @(negedge clk); drive(1'b0, 1'b1, 2'b01, 2'd2, 4'hA, 2'd0, 4'h0); #1;
        check_out("single_req", 2'b01, 4'b0000, 4'h0);
        @(negedge clk); drive(1'b0, 1'b1, 2'b00, 2'd2, 4'hA, 2'd0, 4'h0); #1;
        check_out("single_commit", 2'b00, 4'b0100, 4'hA);
        @(negedge clk); #1;
        check_out("single_idle", 2'b00, 4'b0000, 4'hA);

        // Return rr_ptr to 0 before the alternation sequence
        @(negedge clk); drive(1'b1, 1'b1, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0);

        // Both valid continuously: grants alternate 0,1,... with commits one cycle later
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c < 6) begin
                drive(1'b0, 1'b1, 2'b11, 2'd0, d0_tab[c/2], 2'd3, d1_tab[c/2]);
            end else begin
                drive(1'b0, 1'b1, 2'b00, 2'd0, 4'h0, 2'd3, 4'h0);
            end
            #1;
            check_val($sformatf("alt%0d_ready", c), 32'(bus.req_ready),
                      (c < 6) ? ((c % 2 == 1) ? 32'h2 : 32'h1) : 32'h0);
            if (c > 0) begin
                check_val($sformatf("alt%0d_we", c), 32'(bus.reg_we), 32'(exp_we[c-1]));
                check_val($sformatf("alt%0d_d", c),  32'(bus.reg_d),  32'(exp_d[c-1]));
            end else begin
                check_val("alt0_we", 32'(bus.reg_we), 32'h0);
            end
        end

        // Accept req1, then reset: the pending commit never reaches the bank
        @(negedge clk); drive(1'b0, 1'b1, 2'b10, 2'd0, 4'h0, 2'd1, 4'h5); #1;
        check_val("rstdrop_ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk); drive(1'b1, 1'b1, 2'b00, 2'd0, 4'h0, 2'd1, 4'h5); #1;
        check_val("rstdrop_we",   32'(bus.reg_we), 32'h0);
        check_val("rstdrop_busy", 32'(bus.busy),   32'h0);
        @(negedge clk); drive(1'b0, 1'b1, 2'b11, 2'd0, 4'h6, 2'd3, 4'h7); #1;
        check_out("after_rst", 2'b01, 4'b0000, 4'h0);

        // en=0 blocks new grants while the registered commit still issues
        @(negedge clk); drive(1'b0, 1'b0, 2'b11, 2'd0, 4'h6, 2'd3, 4'h7); #1;
        check_out("en_off0", 2'b00, 4'b0001, 4'h6);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk); #1;
            check_out($sformatf("en_off%0d", i), 2'b00, 4'b0000, 4'h6);
        end
        @(negedge clk); drive(1'b0, 1'b1, 2'b11, 2'd0, 4'h6, 2'd3, 4'h7); #1;
        check_out("en_on", 2'b10, 4'b0000, 4'h6);
        @(negedge clk); drive(1'b0, 1'b1, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0); #1;
        check_out("en_on_commit", 2'b00, 4'b1000, 4'h7);

        // Same address back-to-back: both commits issue, later data last
        @(negedge clk); drive(1'b0, 1'b1, 2'b01, 2'd2, 4'h3, 2'd0, 4'h0); #1;
        check_out("same0", 2'b01, 4'b0000, 4'h7);
        @(negedge clk); drive(1'b0, 1'b1, 2'b01, 2'd2, 4'hC, 2'd0, 4'h0); #1;
        check_out("same1", 2'b01, 4'b0100, 4'h3);
        @(negedge clk); drive(1'b0, 1'b1, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0); #1;
        check_out("same2", 2'b00, 4'b0100, 4'hC);
        @(negedge clk); #1;
        check_out("same3", 2'b00, 4'b0000, 4'hC);

`ifdef REG_ARB_WRCOUNT_EN
        @(negedge clk); drive(1'b1, 1'b1, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0);
        @(negedge clk); drive(1'b0, 1'b1, 2'b01, 2'd1, 4'hF, 2'd0, 4'h0); #1;
        check_val("wrcnt_zero", 32'(wr_count), 32'h0);
        repeat (300) @(negedge clk);
        #1;
        check_val("wrcnt_sat", 32'(wr_count), 32'hFF);
        drive(1'b1, 1'b1, 2'b00, 2'd0, 4'h0, 2'd0, 4'h0);
        @(negedge clk); #1;
        check_val("wrcnt_rst", 32'(wr_count), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
